dog_diff_stage: RTL and testbench
=================================

// Module: dog_diff_stage
// PURPOSE
//  Difference-of-Gaussians stage, directly downstream of gs_filter_top. After start, streams two
//  Gaussian-blurred 8-bit images (narrow sigma in RAM A, wide sigma in RAM B) pixel by pixel.
//  Writes per-pixel difference A-B to an output RAM, then pulses done.
//  RAM read ports follow the mem_wrap en/addr -> data/valid protocol used by the filter.
// PARAMETERS
//  ADDR_W      16     pixel address width
//  DATA_W      8      pixel width (input and output)
//  NPIX        65536  pixels per frame (256x256); addresses 0..NPIX-1
//  FIFO_DEPTH  4      per-channel return buffer depth, power of 2; also max outstanding reads
//  MODE        0      0: |A-B| ; 1: offset-binary (A-B+2^DATA_W)>>1
// PORTS
//  clk              in   1       clock, rising edge
//  rst_n            in   1       asynchronous active-low reset
//  start            in   1       1-cycle pulse; starts a frame when idle
//  rama_rd_valid_o  out  1       RAM A read enable
//  rama_rd_addr_o   out  ADDR_W  RAM A read address
//  rama_valid_in    in   1       RAM A read data valid
//  rama_data_in     in   DATA_W  RAM A read data
//  ramb_rd_valid_o  out  1       RAM B read enable
//  ramb_rd_addr_o   out  ADDR_W  RAM B read address
//  ramb_valid_in    in   1       RAM B read data valid
//  ramb_data_in     in   DATA_W  RAM B read data
//  wr_valid_o       out  1       output RAM write enable
//  wr_addr_o        out  ADDR_W  output RAM write address
//  wr_data_o        out  DATA_W  difference pixel
//  busy             out  1       high from start accept through done pulse
//  done             out  1       1-cycle pulse after final write
//  ovf_o            out  1       sticky: return arrived into a full FIFO (data dropped)
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; counters, FIFOs and ovf_o cleared. Async reset mid-frame aborts;
//   no partial done.
//  FSM IDLE->RUN on start; RUN->DRAIN when rd_cnt==NPIX; DRAIN->DONE when wr_cnt==NPIX;
//   DONE->IDLE after one cycle.
//  start outside IDLE is ignored. start in IDLE clears ovf_o, rd_cnt, wr_cnt and outstanding.
//  Issue in RUN: when outstanding<FIFO_DEPTH, assert rama_rd_valid_o and ramb_rd_valid_o together.
//   Both addresses = rd_cnt; rd_cnt++. Reads to A and B are always issued in lockstep.
//  rd_*_o are registered. Read enables are 0 in every state except RUN.
//  Returns: each *_valid_in pushes *_data_in into its own FIFO, with no bypass. A and B returns may
//   arrive on different cycles; the FIFOs realign them.
//  Pop: in any cycle both FIFOs are non-empty, pop one entry from each and outstanding--.
//   outstanding is updated as +issue-pop; simultaneous issue and pop leaves it unchanged.
//  Write: the cycle after a pop, wr_valid_o=1, wr_addr_o=wr_cnt, wr_data_o=f(a,b); wr_cnt++.
//   wr_addr_o is sequential 0..NPIX-1.
//  Latency: issue -> data return (RAM latency L) -> +1 FIFO -> +1 output register. First write
//   lands L+2 cycles after the first issue; throughput is 1 pixel/cycle when L+2<=FIFO_DEPTH.
//  Arithmetic: d = {1'b0,a} - {1'b0,b}, DATA_W+1 bits, signed.
//   MODE0: |d|; max 255, no saturation needed.
//   MODE1: (d + 2^DATA_W) >> 1, so a=b gives 128, a=255/b=0 gives 255, a=0/b=255 gives 0.
//  Overflow: a valid_in into a full FIFO drops the data and sets ovf_o. This cannot happen under the
//   protocol; ovf_o exists for verification.
//  done: asserted in DONE for exactly 1 cycle; busy falls together with done.
//  Counters: rd_cnt and wr_cnt are ADDR_W+1 bits, so NPIX=2^ADDR_W terminates without wrap.
//   Address outputs are the low ADDR_W bits.
// STRUCTURE
//  Shared package dog_pkg: FSM state enum (IDLE/RUN/DRAIN/DONE), MODE encodings, default ADDR_W,
//   DATA_W and NPIX.
//  Sub-module dog_ret_fifo (synchronous FIFO, DEPTH/WIDTH params, push/pop/full/empty/ovf),
//   instantiated twice.
//  Top holds the FSM, counters, outstanding tracker, difference ALU and output register.
// TESTING
//  1 Ramp frame, A[i]=i[7:0], B=0, MODE0, 1-cycle mem_wrap -> out[i]=i[7:0]; exactly 65536 writes;
//    done 1 pulse.
//  2 A=10, B=200 everywhere, MODE0 -> all 190. MODE1 -> all (10-200+256)>>1 = 33.
//    Also check corner pairs 255/0 -> 255 and 0/255 -> 0.
//  3 B returns delayed 3 cycles vs A -> outputs still pair by address. Issue stalls at 4 outstanding.
//    ovf_o stays 0.
//  4 start pulsed again mid-RUN -> ignored; wr_addr continues sequentially; exactly one done.
//  5 rst_n low mid-frame -> all outputs 0 asynchronously. A fresh start then completes a full frame
//    from addr 0.
//  6 Inject a spurious rama_valid_in with the FIFO full -> ovf_o=1 sticky. The next start clears it.

Source files
------------

// File: rtl/dog_pkg.sv
// Shared definitions for the difference-of-Gaussians stage: FSM encodings,
// arithmetic mode selectors and default frame geometry.
package dog_pkg;

  localparam int DOG_ADDR_W = 16;
  localparam int DOG_DATA_W = 8;
  localparam int DOG_NPIX   = 65536;

  localparam int MODE_ABS    = 0;
  localparam int MODE_OFFSET = 1;

  typedef logic [1:0] dog_state_t;

  localparam dog_state_t ST_IDLE  = 2'd0;
  localparam dog_state_t ST_RUN   = 2'd1;
  localparam dog_state_t ST_DRAIN = 2'd2;
  localparam dog_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/dog_ret_fifo.sv
// Small synchronous return buffer. A push into a full FIFO is dropped and
// flagged on ovf for one cycle; clr empties it without touching storage.
module dog_ret_fifo
  import dog_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             ovf
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit separates the full and empty cases when the indices match.
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign ovf     = push && full;
  assign dout    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/dog_diff_stage.sv
// Difference-of-Gaussians stage: reads the narrow and wide blurred frames in
// lockstep, realigns the returns in per-channel FIFOs and writes f(A,B).
module dog_diff_stage
  import dog_pkg::*;
#(
  parameter int ADDR_W     = DOG_ADDR_W,
  parameter int DATA_W     = DOG_DATA_W,
  parameter int NPIX       = DOG_NPIX,
  parameter int FIFO_DEPTH = 4,
  parameter int MODE       = MODE_ABS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rama_rd_valid_o,
  output logic [ADDR_W-1:0] rama_rd_addr_o,
  input  logic              rama_valid_in,
  input  logic [DATA_W-1:0] rama_data_in,
  output logic              ramb_rd_valid_o,
  output logic [ADDR_W-1:0] ramb_rd_addr_o,
  input  logic              ramb_valid_in,
  input  logic [DATA_W-1:0] ramb_data_in,
  output logic              wr_valid_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              busy,
  output logic              done,
  output logic              ovf_o
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int OUT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(NPIX);
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(FIFO_DEPTH);

  dog_state_t        state;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic [OUT_W-1:0]  outstanding;
  logic              start_acc;
  logic              active;
  logic              issue;
  logic              pop;
  logic              a_full;
  logic              a_empty;
  logic              a_ovf;
  logic              b_full;
  logic              b_empty;
  logic              b_ovf;
  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] b_data;
  logic [DATA_W:0]   d;
  logic [DATA_W-1:0] diff;

  assign start_acc = start && (state == ST_IDLE);
  assign active    = (state == ST_RUN) || (state == ST_DRAIN);
  // The full checks are implied by the outstanding limit; kept as a backstop.
  assign issue     = (state == ST_RUN) && (rd_cnt != LAST) && (outstanding < MAX_OUT)
                     && !a_full && !b_full;
  assign pop       = active && !a_empty && !b_empty;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  dog_ret_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_acc),
    .push  (rama_valid_in),
    .pop   (pop),
    .din   (rama_data_in),
    .dout  (a_data),
    .full  (a_full),
    .empty (a_empty),
    .ovf   (a_ovf)
  );

  dog_ret_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_acc),
    .push  (ramb_valid_in),
    .pop   (pop),
    .din   (ramb_data_in),
    .dout  (b_data),
    .full  (b_full),
    .empty (b_empty),
    .ovf   (b_ovf)
  );

  // Offset-binary adds 2^DATA_W, which in DATA_W+1 bits just flips the sign bit.
  assign d = {1'b0, a_data} - {1'b0, b_data};

  always_comb begin
    diff = d[DATA_W-1:0];
    if (MODE == MODE_OFFSET) begin
      diff = {~d[DATA_W], d[DATA_W-1:1]};
    end else if (d[DATA_W]) begin
      diff = b_data - a_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) state <= ST_RUN;
        ST_RUN:   if (rd_cnt == LAST) state <= ST_DRAIN;
        ST_DRAIN: if (wr_cnt == LAST) state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      outstanding <= '0;
      ovf_o       <= 1'b0;
    end else if (start_acc) begin
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      outstanding <= '0;
      ovf_o       <= 1'b0;
    end else begin
      if (issue) rd_cnt <= rd_cnt + 1'b1;
      if (pop)   wr_cnt <= wr_cnt + 1'b1;
      if (issue && !pop)      outstanding <= outstanding + 1'b1;
      else if (!issue && pop) outstanding <= outstanding - 1'b1;
      if (a_ovf || b_ovf) ovf_o <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rama_rd_valid_o <= 1'b0;
      rama_rd_addr_o  <= '0;
      ramb_rd_valid_o <= 1'b0;
      ramb_rd_addr_o  <= '0;
    end else begin
      rama_rd_valid_o <= issue;
      ramb_rd_valid_o <= issue;
      if (issue) begin
        rama_rd_addr_o <= rd_cnt[ADDR_W-1:0];
        ramb_rd_addr_o <= rd_cnt[ADDR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_valid_o <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
    end else begin
      wr_valid_o <= pop;
      if (pop) begin
        wr_addr_o <= wr_cnt[ADDR_W-1:0];
        wr_data_o <= diff;
      end
    end
  end

endmodule

// File: tb/tb_dog_diff_stage.sv
// Scoreboard bench for dog_diff_stage: two instances (|A-B| and offset-binary)
// share one latency-configurable RAM model; expectations are queued at issue.
module tb_dog_diff_stage;
  import dog_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int NPIX   = 256;
  localparam int DEPTH  = 4;
  localparam int LMAX   = 8;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] d0;
    logic [7:0] d1;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       rama_valid_in, ramb_valid_in;
  logic [7:0] rama_data_in, ramb_data_in;

  logic       rdA_v0, rdB_v0, wr_v0, busy0, done0, ovf0;
  logic [7:0] rdA_a0, rdB_a0, wr_a0, wr_d0;
  logic       rdA_v1, rdB_v1, wr_v1, busy1, done1, ovf1;
  logic [7:0] rdA_a1, rdB_a1, wr_a1, wr_d1;

  logic [7:0]        mem_a [NPIX];
  logic [7:0]        mem_b [NPIX];
  logic [LMAX-1:0]   pipe_va, pipe_vb;
  logic [ADDR_W-1:0] pipe_aa [LMAX];
  logic [ADDR_W-1:0] pipe_ab [LMAX];
  int                lat_a, lat_b;
  logic              inj_a;

  exp_t sb_q[$];
  int   nChecks = 0;
  int   nPass = 0;
  int   cyc = 0;
  int   next_rd, frameWrites, doneCnt, maxOut, firstIss, firstWr;
  logic prevDone;

  dog_diff_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NPIX(NPIX),
                   .FIFO_DEPTH(DEPTH), .MODE(MODE_ABS)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rama_rd_valid_o(rdA_v0), .rama_rd_addr_o(rdA_a0),
    .rama_valid_in(rama_valid_in), .rama_data_in(rama_data_in),
    .ramb_rd_valid_o(rdB_v0), .ramb_rd_addr_o(rdB_a0),
    .ramb_valid_in(ramb_valid_in), .ramb_data_in(ramb_data_in),
    .wr_valid_o(wr_v0), .wr_addr_o(wr_a0), .wr_data_o(wr_d0),
    .busy(busy0), .done(done0), .ovf_o(ovf0)
  );

  dog_diff_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NPIX(NPIX),
                   .FIFO_DEPTH(DEPTH), .MODE(MODE_OFFSET)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rama_rd_valid_o(rdA_v1), .rama_rd_addr_o(rdA_a1),
    .rama_valid_in(rama_valid_in), .rama_data_in(rama_data_in),
    .ramb_rd_valid_o(rdB_v1), .ramb_rd_addr_o(rdB_a1),
    .ramb_valid_in(ramb_valid_in), .ramb_data_in(ramb_data_in),
    .wr_valid_o(wr_v1), .wr_addr_o(wr_a1), .wr_data_o(wr_d1),
    .busy(busy1), .done(done1), .ovf_o(ovf1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: read requests travel down a delay line, each channel taps it at its own latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_va <= '0;
      pipe_vb <= '0;
      for (int i = 0; i < LMAX; i++) begin
        pipe_aa[i] <= '0;
        pipe_ab[i] <= '0;
      end
    end else begin
      pipe_va <= {pipe_va[LMAX-2:0], rdA_v0};
      pipe_vb <= {pipe_vb[LMAX-2:0], rdB_v0};
      pipe_aa[0] <= rdA_a0;
      pipe_ab[0] <= rdB_a0;
      for (int i = 1; i < LMAX; i++) begin
        pipe_aa[i] <= pipe_aa[i-1];
        pipe_ab[i] <= pipe_ab[i-1];
      end
    end
  end

  assign rama_valid_in = pipe_va[lat_a-1] | inj_a;
  assign rama_data_in  = mem_a[pipe_aa[lat_a-1]];
  assign ramb_valid_in = pipe_vb[lat_b-1];
  assign ramb_data_in  = mem_b[pipe_ab[lat_b-1]];

  function automatic logic [7:0] expAbs(input int a, input int b);
    int r;
    r = (a > b) ? a - b : b - a;
    return r[7:0];
  endfunction

  function automatic logic [7:0] expOff(input int a, input int b);
    int r;
    r = (a - b + 256) / 2;
    return r[7:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Issue/write/done monitor; expectations are queued the moment a read is issued.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (rdA_v0 || rdB_v0 || rdA_v1 || rdB_v1) begin
        checkOutput("rd_lockstep", {rdA_v0, rdB_v0}, 2'b11);
        checkOutput("rd_addr", {rdA_a0, rdB_a0}, {next_rd[7:0], next_rd[7:0]});
        checkOutput("rd_dut1", {rdA_v1, rdB_v1, rdA_a1, rdB_a1},
                    {2'b11, next_rd[7:0], next_rd[7:0]});
        checkOutput("rd_in_range", next_rd < NPIX, 1);
        e.addr = next_rd[7:0];
        e.d0   = expAbs(int'(mem_a[next_rd[7:0]]), int'(mem_b[next_rd[7:0]]));
        e.d1   = expOff(int'(mem_a[next_rd[7:0]]), int'(mem_b[next_rd[7:0]]));
        sb_q.push_back(e);
        if (next_rd == 0) firstIss <= cyc;
        next_rd <= next_rd + 1;
      end
      if (wr_v0 || wr_v1) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_underflow", 1, 0);
        end else begin
          e = sb_q.pop_front();
          checkOutput("wr_valid", {wr_v0, wr_v1}, 2'b11);
          checkOutput("wr_addr", {wr_a0, wr_a1}, {e.addr, e.addr});
          checkOutput("wr_data_mode0", wr_d0, e.d0);
          checkOutput("wr_data_mode1", wr_d1, e.d1);
        end
        if (frameWrites == 0) firstWr <= cyc;
        frameWrites <= frameWrites + 1;
      end
      if ((next_rd + int'(rdA_v0)) - (frameWrites + int'(wr_v0)) > maxOut)
        maxOut <= (next_rd + int'(rdA_v0)) - (frameWrites + int'(wr_v0));
      if (done0) begin
        doneCnt <= doneCnt + 1;
        checkOutput("busy_at_done", {busy0, busy1}, 2'b11);
        checkOutput("done_dut1", done1, 1);
        checkOutput("writes_at_done", frameWrites, NPIX);
      end
      if (prevDone) checkOutput("idle_after_done", {busy0, done0, busy1, done1}, 0);
      prevDone <= done0;
    end else begin
      prevDone <= 1'b0;
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ctrl0"}, {rdA_v0, rdB_v0, wr_v0, busy0, done0, ovf0}, 0);
    checkOutput({tag, "_data0"}, {rdA_a0, rdB_a0, wr_a0, wr_d0}, 0);
    checkOutput({tag, "_ctrl1"}, {rdA_v1, rdB_v1, wr_v1, busy1, done1, ovf1}, 0);
    checkOutput({tag, "_data1"}, {rdA_a1, rdB_a1, wr_a1, wr_d1}, 0);
  endtask

  // pat: 0 ramp/zero, 1 constant 10/200, 2 corner pairs, other random.
  task automatic applyStimulus(input int pat, input int la, input int lb);
    for (int i = 0; i < NPIX; i++) begin
      case (pat)
        0: begin mem_a[i] = i[7:0]; mem_b[i] = 8'd0; end
        1: begin mem_a[i] = 8'd10; mem_b[i] = 8'd200; end
        2: begin
          case (i % 4)
            0:       begin mem_a[i] = 8'd255; mem_b[i] = 8'd0;   end
            1:       begin mem_a[i] = 8'd0;   mem_b[i] = 8'd255; end
            2:       begin mem_a[i] = 8'd77;  mem_b[i] = 8'd77;  end
            default: begin mem_a[i] = 8'd200; mem_b[i] = 8'd13;  end
          endcase
        end
        default: begin
          mem_a[i] = 8'($urandom_range(0, 255));
          mem_b[i] = 8'($urandom_range(0, 255));
        end
      endcase
    end
    lat_a = la;
    lat_b = lb;
    next_rd = 0;
    frameWrites = 0;
    doneCnt = 0;
    maxOut = 0;
    firstIss = -1;
    firstWr = -1;
    sb_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", {busy0, busy1}, 2'b11);
    checkOutput("ovf_cleared_by_start", {ovf0, ovf1}, 0);
  endtask

  task automatic waitFrame(input int la, input int lb);
    int guard;
    guard = 0;
    while (doneCnt == 0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("frame_done_seen", doneCnt != 0, 1);
    repeat (5) @(negedge clk);
    checkOutput("done_pulses", doneCnt, 1);
    checkOutput("frame_writes", frameWrites, NPIX);
    checkOutput("sb_empty", sb_q.size(), 0);
    checkOutput("ovf_quiet", {ovf0, ovf1}, 0);
    checkOutput("first_write_latency", firstWr - firstIss, ((la > lb) ? la : lb) + 2);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    inj_a = 1'b0;
    lat_a = 1;
    lat_b = 1;
    prevDone = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkResetOutputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] ramp frame, |A-B|");
    applyStimulus(0, 1, 1);
    waitFrame(1, 1);

    $display("[TB] constant 10/200 frame");
    applyStimulus(1, 1, 1);
    waitFrame(1, 1);

    $display("[TB] corner pairs");
    applyStimulus(2, 1, 1);
    waitFrame(1, 1);

    $display("[TB] B returns 3 cycles after A");
    applyStimulus(3, 1, 4);
    waitFrame(1, 4);
    checkOutput("outstanding_limit", (maxOut >= 4) && (maxOut <= 5), 1);

    $display("[TB] second start while running");
    applyStimulus(3, 2, 2);
    repeat (50) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitFrame(2, 2);

    $display("[TB] reset mid-frame");
    applyStimulus(3, 1, 1);
    repeat (100) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkResetOutputs("abort");
    checkOutput("no_done_on_abort", doneCnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(3, 3, 1);
    waitFrame(3, 1);

    $display("[TB] spurious return into full FIFO");
    @(negedge clk);
    inj_a = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("ovf_fifo_just_full", {ovf0, ovf1}, 0);
    @(negedge clk);
    inj_a = 1'b0;
    checkOutput("ovf_set", {ovf0, ovf1}, 2'b11);
    repeat (3) @(negedge clk);
    checkOutput("ovf_sticky", {ovf0, ovf1}, 2'b11);
    applyStimulus(0, 1, 1);
    waitFrame(1, 1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
